mc_control: RTL

//  Multicycle main-control FSM for the MIPS-lite core. Sequences fetch/decode/execute/writeback over shared ALU,

---
 rtl/mc_pkg.sv | 59 +++++
 rtl/mc_control_if.sv | 34 +++
 rtl/mc_outdec.sv | 69 ++++++
 rtl/mc_control.sv | 78 +++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the MIPS-lite multicycle main control.
// MC_ILLEGAL_TRAP_EN adds the TRAP state for unknown opcodes.
package mc_pkg;

  localparam int unsigned OPW   = 6;
  localparam int unsigned AOPW  = 4;
  localparam int unsigned SELW  = 2;

  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OPW-1:0] OP_ORI   = 6'b001101;

  localparam logic [AOPW-1:0] ALUOP_ADD   = 4'b0000;
  localparam logic [AOPW-1:0] ALUOP_RTYPE = 4'b0001;
  localparam logic [AOPW-1:0] ALUOP_SUB   = 4'b0010;
  localparam logic [AOPW-1:0] ALUOP_AND   = 4'b0100;
  localparam logic [AOPW-1:0] ALUOP_OR    = 4'b1000;

  localparam logic [SELW-1:0] ALUSRCB_B     = 2'b00;
  localparam logic [SELW-1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [SELW-1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [SELW-1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [SELW-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [SELW-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [SELW-1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_RTEXEC, S_RTWB, S_BEQ, S_JUMP,
    S_ADDIEX, S_ANDIEX, S_ORIEX, S_IMMWB
`ifdef MC_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  typedef struct packed {
    logic            pcwrite;
    logic            pcwritecond;
    logic            iord;
    logic            memread;
    logic            memwrite;
    logic            irwrite;
    logic            memtoreg;
    logic            regdst;
    logic            regwrite;
    logic            alusrca;
    logic [SELW-1:0] alusrcb;
    logic [SELW-1:0] pcsource;
    logic [AOPW-1:0] aluop;
    logic            illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle: opcode/ready in, control word out.
interface mc_control_if;
  import mc_pkg::*;

  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            pcwrite;
  logic            pcwritecond;
  logic            iord;
  logic            memread;
  logic            memwrite;
  logic            irwrite;
  logic            memtoreg;
  logic            regdst;
  logic            regwrite;
  logic            alusrca;
  logic [SELW-1:0] alusrcb;
  logic [SELW-1:0] pcsource;
  logic [AOPW-1:0] aluop;
  logic            illegal;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource, aluop, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource, aluop, illegal
  );

endinterface

// File: rtl/mc_outdec.sv
// Moore state -> control-word decode; FETCH write enables wait on mem_ready.
module mc_outdec
  import mc_pkg::*;
(
  input  state_e state,
  input  logic   mem_ready,
  output ctrl_t  ctrl_c
);

  always_comb begin
    ctrl_c = '0;
    case (state)
      S_FETCH: begin
        ctrl_c.memread = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_FOUR;
        ctrl_c.aluop   = ALUOP_ADD;
        ctrl_c.irwrite = mem_ready;
        ctrl_c.pcwrite = mem_ready;
      end
      S_DECODE: ctrl_c.alusrcb = ALUSRCB_IMMSH;
      S_MEMADR: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_c.memread = 1'b1;
        ctrl_c.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_c.memwrite = 1'b1;
        ctrl_c.iord     = 1'b1;
      end
      S_RTEXEC: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.aluop   = ALUOP_RTYPE;
      end
      S_RTWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = 1'b1;
      end
      S_BEQ: begin
        ctrl_c.alusrca     = 1'b1;
        ctrl_c.aluop       = ALUOP_SUB;
        ctrl_c.pcwritecond = 1'b1;
        ctrl_c.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl_c.pcwrite  = 1'b1;
        ctrl_c.pcsource = PCSRC_JUMP;
      end
      S_ADDIEX, S_ANDIEX, S_ORIEX: begin
        ctrl_c.alusrca = 1'b1;
        ctrl_c.alusrcb = ALUSRCB_IMM;
        ctrl_c.aluop   = (state == S_ANDIEX) ? ALUOP_AND :
                         (state == S_ORIEX)  ? ALUOP_OR  : ALUOP_ADD;
      end
      S_IMMWB: ctrl_c.regwrite = 1'b1;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP: ctrl_c.illegal = 1'b1;
`endif
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main-control FSM: state register, next-state logic, reset-gated control word.
// Build with MC_ILLEGAL_TRAP_EN to trap unknown opcodes instead of treating them as NOPs.
module mc_control
  import mc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mc_control_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  dec_c, ctrl_c;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          OP_ORI:       state_d = S_ORIEX;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_RTEXEC: state_d = S_RTWB;
      S_ADDIEX, S_ANDIEX, S_ORIEX: state_d = S_IMMWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:   state_d = S_TRAP;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl_c    (dec_c)
  );

  // Reset blanks every enable and select immediately, even mid-instruction.
  always_comb begin
    ctrl_c = dec_c;
    if (reset) ctrl_c = '0;
  end

  assign bus.pcwrite     = ctrl_c.pcwrite;
  assign bus.pcwritecond = ctrl_c.pcwritecond;
  assign bus.iord        = ctrl_c.iord;
  assign bus.memread     = ctrl_c.memread;
  assign bus.memwrite    = ctrl_c.memwrite;
  assign bus.irwrite     = ctrl_c.irwrite;
  assign bus.memtoreg    = ctrl_c.memtoreg;
  assign bus.regdst      = ctrl_c.regdst;
  assign bus.regwrite    = ctrl_c.regwrite;
  assign bus.alusrca     = ctrl_c.alusrca;
  assign bus.alusrcb     = ctrl_c.alusrcb;
  assign bus.pcsource    = ctrl_c.pcsource;
  assign bus.aluop       = ctrl_c.aluop;
  assign bus.illegal     = ctrl_c.illegal;

endmodule
